// File: rtl/adder_result_buffer.sv
// Two-entry FIFO that captures a 32-bit adder result and derives its status
// flags at push time, so the consumer sees only registered data.
module adder_result_buffer #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic         in_cout,
    input  logic         in_a_msb,
    input  logic         in_b_msb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         out_zero,
    output logic         out_neg,
    output logic         out_lt,
    output logic [7:0]   ovf_count
);

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
        logic         lt;
    } entry_t;

    entry_t     entry_q [2];
    entry_t     entry_d [2];
    logic [1:0] count_q, count_d;
    logic       wrPtr_q, wrPtr_d;
    logic       rdPtr_q, rdPtr_d;
    logic [7:0] ovfCount_q, ovfCount_d;

    entry_t     newEntry;
    logic       doPush;
    logic       doPop;
    logic       newOvf;

    // Signed overflow: same-sign operands producing a result of the other sign.
    assign newOvf = (in_a_msb == in_b_msb) && (in_s[W-1] != in_a_msb);

    always_comb begin
        newEntry      = '0;
        newEntry.s    = in_s;
        newEntry.cout = in_cout;
        newEntry.ovf  = newOvf;
        newEntry.zero = (in_s == '0);
        newEntry.neg  = in_s[W-1];
        newEntry.lt   = in_s[W-1] ^ newOvf;
    end

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q > 2'd0);
    assign doPush    = in_valid && in_ready;
    assign doPop     = out_valid && out_ready;

    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        count_d    = count_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        ovfCount_d = ovfCount_q;

        if (doPush) begin
            entry_d[wrPtr_q] = newEntry;
            wrPtr_d          = ~wrPtr_q;
            if (newOvf && (ovfCount_q != 8'hFF)) begin
                ovfCount_d = ovfCount_q + 8'd1;
            end
        end

        if (doPop) begin
            rdPtr_d = ~rdPtr_q;
        end

        // Push-only grows, pop-only shrinks, both together leave occupancy unchanged.
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            count_q    <= 2'd0;
            wrPtr_q    <= 1'b0;
            rdPtr_q    <= 1'b0;
            ovfCount_q <= 8'd0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            count_q    <= count_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            ovfCount_q <= ovfCount_d;
        end
    end

    assign out_s     = entry_q[rdPtr_q].s;
    assign out_cout  = entry_q[rdPtr_q].cout;
    assign out_ovf   = entry_q[rdPtr_q].ovf;
    assign out_zero  = entry_q[rdPtr_q].zero;
    assign out_neg   = entry_q[rdPtr_q].neg;
    assign out_lt    = entry_q[rdPtr_q].lt;
    assign ovf_count = ovfCount_q;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer: flag vector table, directed
// corner-case sequences and random traffic against a queue-based model.
module tb_adder_result_buffer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        in_cout;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;
    logic        out_lt;
    logic [7:0]  ovf_count;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic        lt;
    } entry_t;

    entry_t modelQ[$];
    int     modelOvfCount = 0;

    adder_result_buffer #(.W(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_cout   (in_cout),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_lt    (out_lt),
        .ovf_count (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference flags from the arithmetic meaning: the true signed sum of the
    // operand signs and the result sign decides overflow and less-than.
    function automatic entry_t makeEntry(input logic [31:0] s, input logic c, input logic a, input logic b);
        entry_t e;
        e.s    = s;
        e.cout = c;
        e.ovf  = (a == b) && (s[31] != a);
        e.zero = (s == 32'd0);
        e.neg  = s[31];
        e.lt   = e.ovf ? ~s[31] : s[31];
        return e;
    endfunction

    task automatic checkOutput();
        check("in_ready", {31'd0, in_ready}, {31'd0, modelQ.size() < 2});
        check("out_valid", {31'd0, out_valid}, {31'd0, modelQ.size() > 0});
        check("ovf_count", {24'd0, ovf_count}, modelOvfCount);
        if (modelQ.size() > 0) begin
            check("out_s", out_s, modelQ[0].s);
            check("out_flags", {26'd0, out_cout, out_ovf, out_zero, out_neg, out_lt},
                  {26'd0, modelQ[0].cout, modelQ[0].ovf, modelQ[0].zero, modelQ[0].neg, modelQ[0].lt});
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] s, input logic c,
                                 input logic a, input logic b, input logic r);
        bit     doPush;
        bit     doPop;
        entry_t e;
        in_valid  = v;
        in_s      = s;
        in_cout   = c;
        in_a_msb  = a;
        in_b_msb  = b;
        out_ready = r;
        doPush    = v && (modelQ.size() < 2);
        doPop     = r && (modelQ.size() > 0);
        e         = makeEntry(s, c, a, b);
        @(posedge clock);
        #1;
        if (doPop) void'(modelQ.pop_front());
        if (doPush) begin
            modelQ.push_back(e);
            if (e.ovf && modelOvfCount < 255) modelOvfCount++;
        end
        checkOutput();
    endtask

    task automatic idle(input logic r);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) idle(1'b1);
    endtask

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        a;
        logic        b;
        logic        expOvf;
        logic        expZero;
        logic        expNeg;
        logic        expLt;
    } vector_t;

    vector_t vecs[8];

    initial begin
        logic [31:0] heldS;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_s      = 32'd0;
        in_cout   = 1'b0;
        in_a_msb  = 1'b0;
        in_b_msb  = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state, including a push attempt that must be ignored.
        in_valid = 1'b1;
        in_s     = 32'hDEAD_BEEF;
        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_ovf_count", {24'd0, ovf_count}, 32'd0);
        check("reset_out_s", out_s, 32'd0);
        check("reset_flags", {27'd0, out_cout, out_ovf, out_zero, out_neg, out_lt}, 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        idle(1'b0);

        // Flag table: each vector pushed into an empty buffer, seen one cycle later.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].s, vecs[i].cout, vecs[i].a, vecs[i].b, 1'b1);
            check("vec_valid", {31'd0, out_valid}, 32'd1);
            check("vec_s", out_s, vecs[i].s);
            check("vec_flags", {27'd0, out_cout, out_ovf, out_zero, out_neg, out_lt},
                  {27'd0, vecs[i].cout, vecs[i].expOvf, vecs[i].expZero, vecs[i].expNeg, vecs[i].expLt});
            idle(1'b1);
            check("vec_empty", {31'd0, out_valid}, 32'd0);
        end

        // Stall with two entries, third push refused, then ordered drain.
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        heldS = out_s;
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("stall_stable", out_s, heldS);
        check("stall_head", out_s, 32'h11);
        idle(1'b1);
        check("drain_second", out_s, 32'h22);
        idle(1'b1);
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // Pop at full does not admit a push in the same cycle.
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
        check("full_pop_head", out_s, 32'hA2);
        check("full_pop_ready", {31'd0, in_ready}, 32'd1);
        drain();

        // Simultaneous push and pop at occupancy one.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0, 1'b1);
            check("pushpop_head", out_s, 32'h100 + i);
            check("pushpop_ready", {31'd0, in_ready}, 32'd1);
        end
        drain();

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, rs, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                          $urandom_range(0, 2) != 0);
        end
        drain();

        // Saturation of the overflow counter.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drain();
        check("ovf_saturated", {24'd0, ovf_count}, 32'd255);

        // Asynchronous reset mid-cycle with the buffer full.
        applyStimulus(1'b1, 32'hBB1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBB2, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_ovf_count", {24'd0, ovf_count}, 32'd0);
        check("async_out_s", out_s, 32'd0);
        modelQ.delete();
        modelOvfCount = 0;
        in_valid = 1'b1;
        in_s     = 32'hCC;
        @(posedge clock);
        #1;
        check("reset_no_push", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        idle(1'b0);
        idle(1'b1);
        check("no_stale_entry", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
